// File: rtl/kv_store_pkg.sv
// kv_store_pkg: shared types for the kv_store key/value block.
//   op_e        - bus opcode carried on ADR_i
//   state_e     - controller states
//   op_needs_we - returns the WE_i level an opcode must arrive with
package kv_store_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'd0,
        OP_INSERT = 2'd1,
        OP_DELETE = 2'd2,
        OP_STATUS = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_e;

    // Mutating opcodes must be issued as writes, queries as reads.
    function automatic logic op_needs_we(input op_e op);
        logic need;
        case (op)
            OP_INSERT, OP_DELETE: need = 1'b1;
            default:              need = 1'b0;
        endcase
        return need;
    endfunction

endpackage

// File: rtl/kv_entry_array.sv
// kv_entry_array: key/value/valid storage for kv_store.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_rd_idx                combinational read index
//   o_rd_key/val/valid      entry contents at i_rd_idx
//   i_wr_en                 write key/value at i_wr_idx and mark it valid
//   i_inv_en                clear the valid bit at i_wr_idx
//   i_wr_idx/key/val        write port operands
module kv_entry_array
    import kv_store_pkg::*;
#(
    parameter  int KEY_W = 16,
    parameter  int VAL_W = 16,
    parameter  int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [KEY_W-1:0] o_rd_key,
    output logic [VAL_W-1:0] o_rd_val,
    output logic             o_rd_valid,
    input  logic             i_wr_en,
    input  logic             i_inv_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [KEY_W-1:0] i_wr_key,
    input  logic [VAL_W-1:0] i_wr_val
);

    logic [KEY_W-1:0] r_key   [DEPTH];
    logic [VAL_W-1:0] r_val   [DEPTH];
    logic [DEPTH-1:0] r_valid;

    // Storage update: reset wipes everything, otherwise one write or invalidate per cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_key[i] <= {KEY_W{1'b0}};
                r_val[i] <= {VAL_W{1'b0}};
            end
        end else if (i_wr_en) begin
            r_key[i_wr_idx]   <= i_wr_key;
            r_val[i_wr_idx]   <= i_wr_val;
            r_valid[i_wr_idx] <= 1'b1;
        end else if (i_inv_en) begin
            r_valid[i_wr_idx] <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign o_rd_key   = r_key[i_rd_idx];
    assign o_rd_val   = r_val[i_rd_idx];
    assign o_rd_valid = r_valid[i_rd_idx];

endmodule

// File: rtl/kv_store.sv
// kv_store: key/value store behind a pipelined Wishbone-style slave port.
// Commands are accepted in IDLE, matched by a one-entry-per-clock scan and
// applied in COMMIT together with a one-cycle ACK_o.
// Ports:
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   CYC_i, STB_i, WE_i      bus cycle / strobe / write enable
//   ADR_i                   opcode (LOOKUP, INSERT, DELETE, STATUS)
//   KEY_i, DAT_i            key and value operands
//   STALL_o, ACK_o, ERR_o   handshake and error flag
//   DAT_o, LA_o             response data and its analyser mirror
//   COUNT_o                 number of valid entries
// Build option: define KV_STORE_EARLY_EXIT_EN to let LOOKUP/DELETE leave the
// scan on the first hit.
module kv_store
    import kv_store_pkg::*;
#(
    parameter  int KEY_W = 16,
    parameter  int VAL_W = 16,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             CYC_i,
    input  logic             STB_i,
    input  logic             WE_i,
    input  logic [1:0]       ADR_i,
    input  logic [KEY_W-1:0] KEY_i,
    input  logic [VAL_W-1:0] DAT_i,
    output logic             STALL_o,
    output logic             ACK_o,
    output logic             ERR_o,
    output logic [VAL_W-1:0] DAT_o,
    output logic [CNT_W-1:0] COUNT_o,
    output logic [VAL_W-1:0] LA_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e           r_state;
    op_e              r_op;
    logic             r_illegal;
    logic [KEY_W-1:0] r_key;
    logic [VAL_W-1:0] r_val;
    logic [IDX_W-1:0] r_idx;
    logic             r_hit;
    logic [IDX_W-1:0] r_hit_idx;
    logic [VAL_W-1:0] r_hit_val;
    logic             r_free;
    logic [IDX_W-1:0] r_free_idx;

    logic [KEY_W-1:0] w_rd_key;
    logic [VAL_W-1:0] w_rd_val;
    logic             w_rd_valid;
    logic             w_hit;
    logic             w_early;
    logic             w_acc_illegal;
    logic             w_wr_en;
    logic             w_inv_en;
    logic [IDX_W-1:0] w_wr_idx;

    kv_entry_array #(
        .KEY_W (KEY_W),
        .VAL_W (VAL_W),
        .DEPTH (DEPTH)
    ) u_array (
        .i_clk      (sys_clk),
        .i_rst      (sys_rst),
        .i_rd_idx   (r_idx),
        .o_rd_key   (w_rd_key),
        .o_rd_val   (w_rd_val),
        .o_rd_valid (w_rd_valid),
        .i_wr_en    (w_wr_en),
        .i_inv_en   (w_inv_en),
        .i_wr_idx   (w_wr_idx),
        .i_wr_key   (r_key),
        .i_wr_val   (r_val)
    );

    // Match of the entry under the scan index, early-exit decision and opcode legality.
    always_comb begin
        w_hit         = w_rd_valid && (w_rd_key == r_key);
        w_acc_illegal = (WE_i != op_needs_we(op_e'(ADR_i)));
`ifdef KV_STORE_EARLY_EXIT_EN
        w_early = w_hit && ((r_op == OP_LOOKUP) || (r_op == OP_DELETE));
`else
        w_early = 1'b0;
`endif
    end

    // Storage write strobes; only fire on the ACK edge of a live, legal command.
    always_comb begin
        w_wr_en  = 1'b0;
        w_inv_en = 1'b0;
        w_wr_idx = r_free_idx;
        if ((r_state == COMMIT) && CYC_i && !r_illegal) begin
            case (r_op)
                OP_INSERT: begin
                    if (r_hit) begin
                        w_wr_en  = 1'b1;
                        w_wr_idx = r_hit_idx;
                    end else begin
                        w_wr_en  = r_free;
                        w_wr_idx = r_free_idx;
                    end
                end
                OP_DELETE: begin
                    w_inv_en = r_hit;
                    w_wr_idx = r_hit_idx;
                end
                default: begin
                    w_wr_en  = 1'b0;
                    w_inv_en = 1'b0;
                end
            endcase
        end else begin
            w_wr_en  = 1'b0;
            w_inv_en = 1'b0;
        end
    end

    // Controller FSM with registered bus outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_op       <= OP_LOOKUP;
            r_illegal  <= 1'b0;
            r_key      <= {KEY_W{1'b0}};
            r_val      <= {VAL_W{1'b0}};
            r_idx      <= {IDX_W{1'b0}};
            r_hit      <= 1'b0;
            r_hit_idx  <= {IDX_W{1'b0}};
            r_hit_val  <= {VAL_W{1'b0}};
            r_free     <= 1'b0;
            r_free_idx <= {IDX_W{1'b0}};
            STALL_o    <= 1'b0;
            ACK_o      <= 1'b0;
            ERR_o      <= 1'b0;
            DAT_o      <= {VAL_W{1'b0}};
            LA_o       <= {VAL_W{1'b0}};
            COUNT_o    <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    ACK_o <= 1'b0;
                    if (CYC_i && STB_i) begin
                        r_op       <= op_e'(ADR_i);
                        r_illegal  <= w_acc_illegal;
                        r_key      <= KEY_i;
                        r_val      <= DAT_i;
                        r_idx      <= {IDX_W{1'b0}};
                        r_hit      <= 1'b0;
                        r_hit_idx  <= {IDX_W{1'b0}};
                        r_hit_val  <= {VAL_W{1'b0}};
                        r_free     <= 1'b0;
                        r_free_idx <= {IDX_W{1'b0}};
                        STALL_o    <= 1'b1;
                        // Illegal commands and STATUS answer on the next edge.
                        if (w_acc_illegal || (op_e'(ADR_i) == OP_STATUS)) begin
                            r_state <= COMMIT;
                        end else begin
                            r_state <= SCAN;
                        end
                    end else begin
                        STALL_o <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!CYC_i) begin
                        r_state <= IDLE;
                        STALL_o <= 1'b0;
                    end else begin
                        if (w_hit) begin
                            r_hit     <= 1'b1;
                            r_hit_idx <= r_idx;
                            r_hit_val <= w_rd_val;
                        end
                        // Keep only the lowest-index free slot.
                        if (!w_rd_valid && !r_free) begin
                            r_free     <= 1'b1;
                            r_free_idx <= r_idx;
                        end
                        if ((r_idx == LAST_IDX) || w_early) begin
                            r_state <= COMMIT;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    r_state <= IDLE;
                    STALL_o <= 1'b0;
                    if (CYC_i) begin
                        ACK_o <= 1'b1;
                        if (r_illegal) begin
                            ERR_o <= 1'b1;
                            DAT_o <= {VAL_W{1'b0}};
                            LA_o  <= {VAL_W{1'b0}};
                        end else begin
                            case (r_op)
                                OP_STATUS: begin
                                    ERR_o <= 1'b0;
                                    DAT_o <= VAL_W'(COUNT_o);
                                    LA_o  <= VAL_W'(COUNT_o);
                                end
                                OP_LOOKUP: begin
                                    ERR_o <= !r_hit;
                                    DAT_o <= r_hit ? r_hit_val : {VAL_W{1'b0}};
                                    LA_o  <= r_hit ? r_hit_val : {VAL_W{1'b0}};
                                end
                                OP_INSERT: begin
                                    if (r_hit) begin
                                        ERR_o <= 1'b0;
                                        DAT_o <= VAL_W'(r_hit_idx);
                                        LA_o  <= VAL_W'(r_hit_idx);
                                    end else if (r_free) begin
                                        ERR_o   <= 1'b0;
                                        DAT_o   <= VAL_W'(r_free_idx);
                                        LA_o    <= VAL_W'(r_free_idx);
                                        COUNT_o <= COUNT_o + CNT_W'(1);
                                    end else begin
                                        ERR_o <= 1'b1;
                                        DAT_o <= {VAL_W{1'b0}};
                                        LA_o  <= {VAL_W{1'b0}};
                                    end
                                end
                                default: begin
                                    // OP_DELETE
                                    ERR_o <= !r_hit;
                                    DAT_o <= r_hit ? r_hit_val : {VAL_W{1'b0}};
                                    LA_o  <= r_hit ? r_hit_val : {VAL_W{1'b0}};
                                    if (r_hit) begin
                                        COUNT_o <= COUNT_o - CNT_W'(1);
                                    end
                                end
                            endcase
                        end
                    end else begin
                        ACK_o <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    STALL_o <= 1'b0;
                    ACK_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kv_store.sv
// tb_kv_store: scoreboard bench for kv_store (DEPTH=8). A reference model of
// the entry table predicts every response; predictions are queued when a
// command is driven and popped when ACK_o appears.
module tb_kv_store;
    import kv_store_pkg::*;

    localparam int KEY_W = 16;
    localparam int VAL_W = 16;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             CYC_i = 1'b0;
    logic             STB_i = 1'b0;
    logic             WE_i = 1'b0;
    logic [1:0]       ADR_i = 2'd0;
    logic [KEY_W-1:0] KEY_i = 16'h0000;
    logic [VAL_W-1:0] DAT_i = 16'h0000;
    logic             STALL_o;
    logic             ACK_o;
    logic             ERR_o;
    logic [VAL_W-1:0] DAT_o;
    logic [CNT_W-1:0] COUNT_o;
    logic [VAL_W-1:0] LA_o;

    kv_store #(.KEY_W(KEY_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .CYC_i   (CYC_i),
        .STB_i   (STB_i),
        .WE_i    (WE_i),
        .ADR_i   (ADR_i),
        .KEY_i   (KEY_i),
        .DAT_i   (DAT_i),
        .STALL_o (STALL_o),
        .ACK_o   (ACK_o),
        .ERR_o   (ERR_o),
        .DAT_o   (DAT_o),
        .COUNT_o (COUNT_o),
        .LA_o    (LA_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        err;
        logic [15:0] dat;
        int          cnt;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    logic [15:0] m_key   [DEPTH];
    logic [15:0] m_val   [DEPTH];
    logic        m_valid [DEPTH];
    int          m_count = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_key[i]   = 16'h0000;
            m_val[i]   = 16'h0000;
            m_valid[i] = 1'b0;
        end
        m_count = 0;
    endtask

    // Predict the response of one command and update the model accordingly.
    task automatic predict(input logic [1:0] adr, input logic we, input logic [15:0] key,
                           input logic [15:0] dat, output exp_t e);
        int  hit;
        int  free;
        logic legal;
        hit  = -1;
        free = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && m_key[i] == key && hit < 0) hit = i;
            if (!m_valid[i] && free < 0) free = i;
        end
        legal = (we == ((adr == 2'd1) || (adr == 2'd2)));
        e.err = 1'b0;
        e.dat = 16'h0000;
        e.lat = DEPTH + 1;
        if (!legal) begin
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            case (adr)
                2'd0: begin
                    if (hit >= 0) begin
                        e.dat = m_val[hit];
`ifdef KV_STORE_EARLY_EXIT_EN
                        e.lat = hit + 2;
`endif
                    end else e.err = 1'b1;
                end
                2'd1: begin
                    if (hit >= 0) begin
                        m_val[hit] = dat;
                        e.dat = 16'(hit);
                    end else if (free >= 0) begin
                        m_key[free] = key;
                        m_val[free] = dat;
                        m_valid[free] = 1'b1;
                        m_count++;
                        e.dat = 16'(free);
                    end else e.err = 1'b1;
                end
                2'd2: begin
                    if (hit >= 0) begin
                        e.dat = m_val[hit];
                        m_valid[hit] = 1'b0;
                        m_count--;
`ifdef KV_STORE_EARLY_EXIT_EN
                        e.lat = hit + 2;
`endif
                    end else e.err = 1'b1;
                end
                default: begin
                    e.dat = 16'(m_count);
                    e.lat = 1;
                end
            endcase
        end
        e.cnt = m_count;
    endtask

    // Drive one command, wait (bounded) for ACK_o, compare against the queued prediction.
    task automatic cmd(input string tag, input logic [1:0] adr, input logic we,
                       input logic [15:0] key, input logic [15:0] dat);
        exp_t e;
        exp_t got;
        int   k;
        logic seen;
        predict(adr, we, key, dat, e);
        sb_q.push_back(e);
        @(negedge sys_clk);
        CYC_i = 1'b1; STB_i = 1'b1; WE_i = we; ADR_i = adr; KEY_i = key; DAT_i = dat;
        @(posedge sys_clk);             // E0
        #1;
        check({tag, "_stall"}, 32'(STALL_o), 32'd1);
        @(negedge sys_clk);
        STB_i = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!seen && k < DEPTH + 6) begin
            @(posedge sys_clk);
            #1;
            k++;
            seen = ACK_o;
        end
        got = sb_q.pop_front();
        check({tag, "_ack_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_latency"}, 32'(k), 32'(got.lat));
            check({tag, "_err"}, 32'(ERR_o), 32'(got.err));
            check({tag, "_dat"}, 32'(DAT_o), 32'(got.dat));
            check({tag, "_la"}, 32'(LA_o), 32'(got.dat));
            check({tag, "_count"}, 32'(COUNT_o), 32'(got.cnt));
            check({tag, "_stall_low"}, 32'(STALL_o), 32'd0);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_stall"}, 32'(STALL_o), 32'd0);
        check({tag, "_ack"},   32'(ACK_o),   32'd0);
        check({tag, "_err"},   32'(ERR_o),   32'd0);
        check({tag, "_dat"},   32'(DAT_o),   32'd0);
        check({tag, "_count"}, 32'(COUNT_o), 32'd0);
        check({tag, "_la"},    32'(LA_o),    32'd0);
    endtask

    initial begin
        int   got_ack;
        model_clear();
        repeat (2) @(posedge sys_clk);
        #1;
        check_outputs_zero("reset");
        @(negedge sys_clk);
        sys_rst = 1'b0;

        cmd("status0", 2'd3, 1'b0, 16'h0000, 16'h0000);
        cmd("ins_1234", 2'd1, 1'b1, 16'h1234, 16'hBEEF);
        cmd("look_1234", 2'd0, 1'b0, 16'h1234, 16'h0000);
        for (int i = 1; i < DEPTH; i++) begin
            cmd("ins_fill", 2'd1, 1'b1, 16'h1000 + 16'(i), 16'hA000 + 16'(i));
        end
        cmd("ins_full", 2'd1, 1'b1, 16'h00FF, 16'h1111);
        cmd("ins_upd", 2'd1, 1'b1, 16'h1234, 16'h5555);
        cmd("look_upd", 2'd0, 1'b0, 16'h1234, 16'h0000);
        cmd("look_last", 2'd0, 1'b0, 16'h1007, 16'h0000);
        cmd("del_1003", 2'd2, 1'b1, 16'h1003, 16'h0000);
        cmd("del_again", 2'd2, 1'b1, 16'h1003, 16'h0000);
        cmd("look_del", 2'd0, 1'b0, 16'h1003, 16'h0000);
        cmd("ins_reuse", 2'd1, 1'b1, 16'h2222, 16'h7777);
        cmd("look_we1", 2'd0, 1'b1, 16'h1234, 16'h0000);
        cmd("ins_we0", 2'd1, 1'b0, 16'h3333, 16'h0000);
        cmd("status8", 2'd3, 1'b0, 16'h0000, 16'h0000);
        cmd("del_1001", 2'd2, 1'b1, 16'h1001, 16'h0000);

        // Abort an INSERT mid-scan by dropping CYC_i.
        @(negedge sys_clk);
        CYC_i = 1'b1; STB_i = 1'b1; WE_i = 1'b1; ADR_i = 2'd1; KEY_i = 16'hAAAA; DAT_i = 16'h9999;
        @(negedge sys_clk);
        STB_i = 1'b0;
        repeat (2) @(negedge sys_clk);
        CYC_i = 1'b0;
        got_ack = 0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            @(posedge sys_clk);
            #1;
            if (ACK_o) got_ack++;
        end
        check("abort_noack", 32'(got_ack), 32'd0);
        check("abort_stall", 32'(STALL_o), 32'd0);
        check("abort_count", 32'(COUNT_o), 32'(m_count));
        cmd("look_abort", 2'd0, 1'b0, 16'hAAAA, 16'h0000);

        // Reset in the middle of a LOOKUP scan.
        @(negedge sys_clk);
        CYC_i = 1'b1; STB_i = 1'b1; WE_i = 1'b0; ADR_i = 2'd0; KEY_i = 16'h1234;
        @(negedge sys_clk);
        STB_i = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b1;
        CYC_i = 1'b0;
        @(posedge sys_clk);
        #1;
        check_outputs_zero("midrst");
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_clear();
        cmd("look_after_rst", 2'd0, 1'b0, 16'h1234, 16'h0000);
        cmd("ins_slot0", 2'd1, 1'b1, 16'h0042, 16'hCAFE);
        cmd("look_slot0", 2'd0, 1'b0, 16'h0042, 16'h0000);
        cmd("del_slot0", 2'd2, 1'b1, 16'h0042, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/kv_store.md
# kv_store

Parametrised key/value store with a Wishbone-style pipelined slave port, successor to the fixed 8×16-bit key/value block. It supports lookup by key, insert/update, delete and a status read. Matching uses a sequential scan, one entry per clock, with per-entry valid bits and duplicate-key protection. It sits on the system bus as a memory-mapped slave alongside the existing peripherals.

## Interface
Parameters:
- KEY_W, 16, key width in bits
- VAL_W, 16, value width in bits (≥ $clog2(DEPTH+1))
- DEPTH, 8, number of entries (≥2)

Ports:
- sys_clk  in  1  single clock, all logic on rising edge
- sys_rst  in  1  reset, synchronous, active-high
- CYC_i  in  1  bus cycle active
- STB_i  in  1  strobe, command valid
- WE_i  in  1  write enable
- ADR_i  in  2  opcode: 0 LOOKUP, 1 INSERT, 2 DELETE, 3 STATUS
- KEY_i  in  KEY_W  key operand
- DAT_i  in  VAL_W  value operand (INSERT only)
- STALL_o  out  1  command not accepted this cycle
- ACK_o  out  1  one-cycle response pulse
- ERR_o  out  1  valid with ACK_o: miss, full or illegal op
- DAT_o  out  VAL_W  response data, valid with ACK_o
- COUNT_o  out  $clog2(DEPTH+1)  number of valid entries
- LA_o  out  VAL_W  logic-analyser tap, mirrors DAT_o

## Operation
- States: IDLE, SCAN, COMMIT.
- Accept: in IDLE, CYC_i&STB_i high at an edge E0. The block captures ADR_i, WE_i, KEY_i and DAT_i, and sets STALL_o=1.
- Legality: LOOKUP/STATUS need WE_i=0; INSERT/DELETE need WE_i=1. A mismatch produces an ACK_o+ERR_o pulse at E0+1, DAT_o=0, no state change.
- STATUS: no scan. ACK_o at E0+1, DAT_o=COUNT_o zero-extended, ERR_o=0.
- SCAN: index i=0..DEPTH-1, one per cycle. A hit is recorded as valid[i] && key[i]==captured key. The lowest-index invalid slot is recorded as the free slot.
- COMMIT, applied at the ACK_o edge:
  - LOOKUP: hit gives DAT_o=value, ERR_o=0; miss gives DAT_o=0, ERR_o=1.
  - INSERT: hit overwrites the value (COUNT unchanged). Miss with a free slot writes key/value, sets valid, COUNT+1. Miss with no free slot gives ERR_o=1 and no write. DAT_o = slot index written (zero-extended), else 0.
  - DELETE: hit clears valid, COUNT-1, DAT_o=old value. Miss gives ERR_o=1, DAT_o=0.
- Duplicate keys are never stored.
- CYC_i low during SCAN/COMMIT aborts the command: return to IDLE, no write, no ACK_o, STALL_o=0 next edge.
- sys_rst at any time clears all valid bits, keys, values and COUNT_o, and forces IDLE. All outputs reset to 0.

## Timing
- Reset values: STALL_o=0, ACK_o=0, ERR_o=0, DAT_o=0, COUNT_o=0, LA_o=0.
- Full-scan ops: ACK_o high for exactly the cycle after edge E0+DEPTH+1.
- STALL_o is high from E0 until the ACK_o edge, where it falls.
- A new command may be accepted on the same edge that ACK_o deasserts, giving back-to-back throughput of 1 per DEPTH+2 cycles.
- DAT_o and ERR_o hold their values until the next ACK_o.
- COUNT_o updates on the ACK_o edge.
- Index counter width is $clog2(DEPTH). The index wraps only via the state change, never silently.

## Configuration
- KV_STORE_EARLY_EXIT_EN defined: LOOKUP and DELETE leave SCAN on the first hit at index i, giving ACK_o at E0+i+2. INSERT always scans fully so it can detect duplicates and find a free slot.
- KV_STORE_EARLY_EXIT_EN undefined: fixed latency DEPTH+1 edges for every scanning op.

## Structure
- Package kv_store_pkg holds:
  - op_e enum (OP_LOOKUP=0, OP_INSERT=1, OP_DELETE=2, OP_STATUS=3)
  - state_e enum (IDLE, SCAN, COMMIT)
- Sub-module kv_entry_array holds the key/value/valid storage. It has one combinational read port by index and one synchronous write/invalidate port. The top-level keeps the FSM, capture registers and response logic.

## Test plan
- Reset, then STATUS → ACK_o at E0+1, DAT_o=0, ERR_o=0.
- INSERT key 0x1234 val 0xBEEF, then LOOKUP 0x1234 → DAT_o=0xBEEF, ERR_o=0, COUNT_o=1, ACK_o at E0+9 (DEPTH=8, early-exit off).
- INSERT 8 distinct keys, then INSERT 0x00FF → ERR_o=1, COUNT_o=8. INSERT of an existing key with 0x5555 → ERR_o=0, COUNT_o=8, LOOKUP returns 0x5555.
- DELETE a stored key → DAT_o=old value, COUNT_o−1. Repeat the DELETE → ERR_o=1. LOOKUP of that key → ERR_o=1, DAT_o=0.
- LOOKUP with WE_i=1 → ERR_o pulse at E0+1. Drop CYC_i mid-SCAN on an INSERT → no ACK_o, COUNT_o unchanged, key absent.
- sys_rst asserted mid-SCAN → next cycle all outputs 0, subsequent LOOKUP misses. With KV_STORE_EARLY_EXIT_EN, a hit at slot 0 gives ACK_o at E0+2.
